// File: rtl/rca_mp_add_seq.sv
// Multi-precision add sequencer: streams WORDS x 32-bit slices through one shared
// rca_32bit, LS word first. Define RCA_MP_SUB_EN to add the in_sub (A-B) mode.

module rca_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  logic carry_s;

  // Bit-by-bit ripple; the running carry is a blocking variable so the chain stays acyclic.
  always_comb begin
    carry_s = c_in;
    s       = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s[i]    = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    c_out = carry_s;
  end

endmodule

module rca_mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*WORDS-1:0] in_a,
  input  logic [32*WORDS-1:0] in_b,
  input  logic                in_c,
`ifdef RCA_MP_SUB_EN
  input  logic                in_sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*WORDS-1:0] out_s,
  output logic                out_c,
  output logic                out_ovf,
  output logic                busy
);

  localparam int W  = 32 * WORDS;
  localparam int IW = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
`ifdef RCA_MP_SUB_EN
  logic            sub_r;
`endif

  logic [W-1:0]    a_sh_s;
  logic [W-1:0]    b_sh_s;
  logic [31:0]     a_word_s;
  logic [31:0]     b_word_s;
  logic [31:0]     sum_word_s;
  logic            c_out_s;
  logic            last_s;
  logic            ovf_s;

  // Select the current word slice of the latched operands (B inverted when subtracting).
  always_comb begin
    a_sh_s   = a_r >> {idx_r, 5'd0};
    b_sh_s   = b_r >> {idx_r, 5'd0};
    a_word_s = a_sh_s[31:0];
`ifdef RCA_MP_SUB_EN
    b_word_s = sub_r ? ~b_sh_s[31:0] : b_sh_s[31:0];
`else
    b_word_s = b_sh_s[31:0];
`endif
    last_s   = (idx_r == IW'(WORDS - 1));
    ovf_s    = (a_word_s[31] == b_word_s[31]) && (sum_word_s[31] != a_word_s[31]);
  end

  rca_32bit u_rca (
    .a     (a_word_s),
    .b     (b_word_s),
    .c_in  (carry_r),
    .s     (sum_word_s),
    .c_out (c_out_s)
  );

  // Sequencer FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {IW{1'b0}};
      carry_r   <= 1'b0;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
`ifdef RCA_MP_SUB_EN
      sub_r     <= 1'b0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_s     <= {W{1'b0}};
      out_c     <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            idx_r    <= {IW{1'b0}};
`ifdef RCA_MP_SUB_EN
            sub_r    <= in_sub;
            carry_r  <= in_sub ? 1'b1 : in_c;
`else
            carry_r  <= in_c;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx_r == IW'(w)) out_s[w*32 +: 32] <= sum_word_s;
          end
          carry_r <= c_out_s;
          // Index stops at WORDS-1; leaving RUN is what ends the sweep.
          if (last_s) begin
            out_c     <= c_out_s;
            out_ovf   <= ovf_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_mp_add_seq.sv
// Self-checking bench for rca_mp_add_seq: directed and random requests checked against
// a plain-arithmetic W-bit reference model.

module tb_rca_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c;
`ifdef RCA_MP_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_c;
  logic         out_ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  rca_mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
`ifdef RCA_MP_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, carry, sum} of A + B' + cin over the full W bits.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic sub);
    logic [W-1:0] bp;
    logic         cin;
    logic [W:0]   full;
    logic         ovf;
    bp   = sub ? ~b : b;
    cin  = sub ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_wide(input int mode);
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      case ((mode + i) % 4)
        0:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        1:       v[i*32 +: 32] = 32'h0000_0000;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic scramble_inputs;
    in_a = rand_wide(2);
    in_b = rand_wide(3);
    in_c = 1'($urandom_range(0, 1));
  endtask

  // One request: accept, latency, result, optional back-pressure with in_valid pestering, handshake.
  task automatic do_transaction(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic sub, input int hold);
    logic [W+1:0] exp;
    int           edges;
    exp = ref_add(a, b, c, sub);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
    end
    in_a = a; in_b = b; in_c = c;
`ifdef RCA_MP_SUB_EN
    in_sub = sub;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
`ifdef RCA_MP_SUB_EN
    in_sub = ~sub;
`endif
    edges = 1;
    while (out_valid !== 1'b1 && edges < 4 * WORDS + 10) begin
      @(posedge clk); #1;
      edges++;
    end
    n_tests++;
    if (edges != WORDS + 1) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid after %0d cycles required %0d", name, edges, WORDS + 1);
    end
    n_tests++;
    if (out_s !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL %s_sum: out_s=%h required %h", name, out_s, exp[W-1:0]);
    end
    n_tests++;
    if ({out_c, out_ovf, busy, in_ready} !== {exp[W], exp[W+1], 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_flags: c/ovf/busy/rdy=%b%b%b%b required %b%b10", name,
               out_c, out_ovf, busy, in_ready, exp[W], exp[W+1]);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, out_s, out_c, out_ovf} !== {1'b1, 1'b0, exp[W-1:0], exp[W], exp[W+1]}) begin
        n_fail++;
        $display("FAIL %s_hold%0d: vld=%b rdy=%b s=%h c=%b ovf=%b required vld=1 rdy=0 s=%h", name, h,
                 out_valid, in_ready, out_s, out_c, out_ovf, exp[W-1:0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s_handshake: vld/rdy/busy=%b%b%b required 010", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = {W{1'b0}}; in_b = {W{1'b0}}; in_c = 1'b0;
`ifdef RCA_MP_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, busy, out_c, out_ovf} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/vld/busy/c/ovf=%b%b%b%b%b required 10000",
               in_ready, out_valid, busy, out_c, out_ovf);
    end
    n_tests++;
    if (out_s !== {W{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_sum: out_s=%h required 0", out_s);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ones;
    logic [W-1:0] max_pos;
    ones    = {W{1'b1}};
    max_pos = {1'b0, {(W-1){1'b1}}};
    do_transaction("small", W'(32'h4), W'(32'h5), 1'b0, 1'b0, 0);
    do_transaction("ripple", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, W'(32'h1), 1'b0, 1'b0, 0);
    do_transaction("wrap", ones, {W{1'b0}}, 1'b1, 1'b0, 0);
    do_transaction("ovf", max_pos, W'(32'h1), 1'b0, 1'b0, 0);
    n_tests++;
    if ({out_s[W-1], out_s[W-2:0] == {(W-1){1'b0}}} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_msb: out_s=%h required 8000..0000", out_s);
    end
`ifdef RCA_MP_SUB_EN
    do_transaction("sub_neg", W'(32'h5), W'(32'h6), 1'b0, 1'b1, 0);
    do_transaction("sub_pos", W'(32'h9), W'(32'h4), 1'b1, 1'b1, 0);
`endif
  endtask

  task automatic test_backpressure;
    do_transaction("bp", rand_wide(2), rand_wide(1), 1'b1, 1'b0, 10);
    do_transaction("after_bp", W'(32'h1234), W'(32'h1), 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run;
    in_a = rand_wide(2); in_b = rand_wide(0); in_c = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010 || out_s !== {W{1'b0}}) begin
      n_fail++;
      $display("FAIL midrst_state: vld/rdy/busy=%b%b%b s=%h required 010 s=0", out_valid, in_ready, busy, out_s);
    end
    for (int i = 0; i < WORDS + 2; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_novalid: out_valid=%b required 0 at cycle %0d", out_valid, i);
      end
    end
    do_transaction("after_rst", W'(32'h6), W'(32'h7), 1'b1, 1'b0, 0);
  endtask

  task automatic test_rst_vs_accept;
    in_a = rand_wide(2); in_b = rand_wide(2); in_c = 1'b0;
    in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    n_tests++;
    if ({busy, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_wins: busy/rdy=%b%b required 01", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+1:0] exp;
    int           accepts;
    int           last_acc;
    logic         acc_now;
    int           waited;
    a = rand_wide(2); b = rand_wide(3);
    exp = ref_add(a, b, 1'b1, 1'b0);
    in_a = a; in_b = b; in_c = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    accepts = 0; last_acc = 0;
    for (int cyc = 0; cyc < 6 * (WORDS + 2) && accepts < 3; cyc++) begin
      acc_now = in_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        if (accepts > 0) begin
          n_tests++;
          if (cyc - last_acc != WORDS + 2) begin
            n_fail++;
            $display("FAIL b2b_gap: accept spacing %0d required %0d", cyc - last_acc, WORDS + 2);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (out_s !== exp[W-1:0]) begin
          n_fail++;
          $display("FAIL b2b_sum: out_s=%h required %h", out_s, exp[W-1:0]);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (accepts != 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d accepts required 3", accepts);
    end
    waited = 0;
    while (in_ready !== 1'b1 && waited < 4 * WORDS + 10) begin
      @(posedge clk); #1;
      waited++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: in_ready=%b required 1 within budget", in_ready);
    end
  endtask

  task automatic test_random;
    logic sub;
    for (int i = 0; i < 24; i++) begin
      sub = 1'b0;
`ifdef RCA_MP_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      do_transaction("rand", rand_wide(int'($urandom_range(0, 3))), rand_wide(int'($urandom_range(0, 3))),
                     1'($urandom_range(0, 1)), sub, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_rst_vs_accept();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
